// File: rtl/frame_buffer_ctrl_if.sv
// ----------------------------------------------------------------------------
// frame_buffer_ctrl_if
// Bundles the CPU bus side and the frame buffer port A / VGA config side of
// the frame buffer controller.
//   BUS_ADDR[7:0], BUS_DATA_IN[7:0], BUS_WE : CPU bus access (driven by master)
//   BUS_DATA_OUT[7:0], BUS_DATA_OE          : status read-back
//   FB_ADDR, FB_DATA, FB_WE                 : frame buffer port A write port
//   CONFIG_COLOURS[15:0]                    : {BG,FG} to the VGA generator
//   FILL_DONE                               : pulse after the last fill write
// master = CPU/system side, slave = frame_buffer_ctrl.
// ----------------------------------------------------------------------------
interface frame_buffer_ctrl_if #(
  parameter int ADDR_WIDTH = 15
);
  logic [7:0]            BUS_ADDR;
  logic [7:0]            BUS_DATA_IN;
  logic                  BUS_WE;
  logic [7:0]            BUS_DATA_OUT;
  logic                  BUS_DATA_OE;
  logic [ADDR_WIDTH-1:0] FB_ADDR;
  logic                  FB_DATA;
  logic                  FB_WE;
  logic [15:0]           CONFIG_COLOURS;
  logic                  FILL_DONE;

  modport master (
    output BUS_ADDR, BUS_DATA_IN, BUS_WE,
    input  BUS_DATA_OUT, BUS_DATA_OE, FB_ADDR, FB_DATA, FB_WE,
    input  CONFIG_COLOURS, FILL_DONE
  );

  modport slave (
    input  BUS_ADDR, BUS_DATA_IN, BUS_WE,
    output BUS_DATA_OUT, BUS_DATA_OE, FB_ADDR, FB_DATA, FB_WE,
    output CONFIG_COLOURS, FILL_DONE
  );
endinterface

// File: rtl/frame_buffer_ctrl.sv
// ----------------------------------------------------------------------------
// frame_buffer_ctrl
// Owns frame buffer port A and the VGA colour configuration. CPU bus writes
// set X/Y, write single pixels, set FG/BG colours and start a fill engine that
// sweeps the whole buffer. CPU pixel writes that arrive during a fill are
// parked in a one-deep pending slot and written on the next cycle while the
// fill counter yields.
// Ports:
//   CLK   : system clock
//   RESET : asynchronous, active-high reset
//   bus   : frame_buffer_ctrl_if.slave (CPU bus, port A, colours, FILL_DONE)
// Register map (offsets from BASE_ADDR):
//   +0 X, +1 Y[6:0], +2 pixel (bit0), +3 FG, +4 BG,
//   +5 write: bit0 start fill, bit1 fill value; read: {6'b0,overflow,busy}
// ----------------------------------------------------------------------------
module frame_buffer_ctrl #(
  parameter logic [7:0]  BASE_ADDR       = 8'hB0,
  parameter int          ADDR_WIDTH      = 15,
  parameter logic [15:0] DEFAULT_COLOURS = 16'h00FF
) (
  input  logic                CLK,
  input  logic                RESET,
  frame_buffer_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_r, state_nxt;
  logic [7:0]            x_r;
  logic [6:0]            y_r;
  logic [7:0]            fg_r, bg_r;
  logic [ADDR_WIDTH-1:0] ctr_r, ctr_nxt;
  logic                  fill_val_r, fill_val_nxt;
  logic                  pend_valid_r, pend_valid_nxt;
  logic [ADDR_WIDTH-1:0] pend_addr_r, pend_addr_nxt;
  logic                  pend_data_r, pend_data_nxt;
  logic                  overflow_r, overflow_nxt;
  logic                  fb_we_r, fb_we_nxt;
  logic [ADDR_WIDTH-1:0] fb_addr_r, fb_addr_nxt;
  logic                  fb_data_r, fb_data_nxt;
  logic                  last_r, last_nxt;
  logic                  fill_done_r;
  logic                  oe_r;
  logic [7:0]            dout_r, dout_nxt;

  logic [7:0]            offset_s;
  logic                  in_range_s;
  logic                  wr_x_s, wr_y_s, wr_pix_s, wr_fg_s, wr_bg_s, wr_cmd_s;
  logic                  rd_status_s;
  logic                  busy_s;
  logic [ADDR_WIDTH-1:0] pixel_addr_s;

  // Bus address decode; the lower bound check stops offset wrap-around aliasing
  assign offset_s     = bus.BUS_ADDR - BASE_ADDR;
  assign in_range_s   = (bus.BUS_ADDR >= BASE_ADDR) && (offset_s <= 8'd5);
  assign wr_x_s       = bus.BUS_WE && in_range_s && (offset_s == 8'd0);
  assign wr_y_s       = bus.BUS_WE && in_range_s && (offset_s == 8'd1);
  assign wr_pix_s     = bus.BUS_WE && in_range_s && (offset_s == 8'd2);
  assign wr_fg_s      = bus.BUS_WE && in_range_s && (offset_s == 8'd3);
  assign wr_bg_s      = bus.BUS_WE && in_range_s && (offset_s == 8'd4);
  assign wr_cmd_s     = bus.BUS_WE && in_range_s && (offset_s == 8'd5);
  assign rd_status_s  = !bus.BUS_WE && in_range_s && (offset_s == 8'd5);
  assign busy_s       = (state_r == ST_FILL);
  assign pixel_addr_s = ADDR_WIDTH'({y_r, x_r});

  // X/Y cursor and colour registers, writable at any time
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      x_r  <= 8'h00;
      y_r  <= 7'h00;
      fg_r <= DEFAULT_COLOURS[7:0];
      bg_r <= DEFAULT_COLOURS[15:8];
    end else begin
      if (wr_x_s)  x_r  <= bus.BUS_DATA_IN;
      if (wr_y_s)  y_r  <= bus.BUS_DATA_IN[6:0];
      if (wr_fg_s) fg_r <= bus.BUS_DATA_IN;
      if (wr_bg_s) bg_r <= bus.BUS_DATA_IN;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next state, port A arbitration, pending slot and status read
  always_comb begin
    state_nxt      = state_r;
    ctr_nxt        = ctr_r;
    fill_val_nxt   = fill_val_r;
    pend_valid_nxt = pend_valid_r;
    pend_addr_nxt  = pend_addr_r;
    pend_data_nxt  = pend_data_r;
    overflow_nxt   = overflow_r;
    fb_we_nxt      = 1'b0;
    fb_addr_nxt    = fb_addr_r;
    fb_data_nxt    = fb_data_r;
    last_nxt       = 1'b0;
    dout_nxt       = 8'h00;

    // Port A source: pending pixel first, then the fill sweep, then a direct
    // IDLE pixel write. A pending slot can outlive the fill by one cycle when
    // a pixel lands on the final fill write, so it also drains in IDLE.
    if (pend_valid_r) begin
      fb_we_nxt      = 1'b1;
      fb_addr_nxt    = pend_addr_r;
      fb_data_nxt    = pend_data_r;
      pend_valid_nxt = 1'b0;
    end else if (state_r == ST_FILL) begin
      fb_we_nxt   = 1'b1;
      fb_addr_nxt = ctr_r;
      fb_data_nxt = fill_val_r;
      ctr_nxt     = ctr_r + ADDR_ONE;
      if (ctr_r == LAST_ADDR) begin
        state_nxt = ST_IDLE;
        last_nxt  = 1'b1;
      end else begin
        state_nxt = ST_FILL;
      end
    end else if (wr_pix_s) begin
      fb_we_nxt   = 1'b1;
      fb_addr_nxt = pixel_addr_s;
      fb_data_nxt = bus.BUS_DATA_IN[0];
    end else begin
      fb_we_nxt = 1'b0;
    end

    // Pixel writes that cannot go out directly: park or drop
    if (wr_pix_s) begin
      if (pend_valid_r) begin
        overflow_nxt = 1'b1;
      end else if (state_r == ST_FILL) begin
        pend_valid_nxt = 1'b1;
        pend_addr_nxt  = pixel_addr_s;
        pend_data_nxt  = bus.BUS_DATA_IN[0];
      end else begin
        pend_valid_nxt = pend_valid_nxt;
      end
    end else begin
      pend_valid_nxt = pend_valid_nxt;
    end

    // Start command is only honoured from IDLE; the counter is already 0 there
    if (wr_cmd_s && bus.BUS_DATA_IN[0] && (state_r == ST_IDLE)) begin
      state_nxt    = ST_FILL;
      fill_val_nxt = bus.BUS_DATA_IN[1];
    end else begin
      fill_val_nxt = fill_val_nxt;
    end

    // Status read returns the flags seen this cycle and clears overflow
    if (rd_status_s) begin
      dout_nxt     = {6'b000000, overflow_r, busy_s};
      overflow_nxt = 1'b0;
    end else begin
      dout_nxt = 8'h00;
    end
  end

  // Datapath registers and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ctr_r        <= '0;
      fill_val_r   <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_addr_r  <= '0;
      pend_data_r  <= 1'b0;
      overflow_r   <= 1'b0;
      fb_we_r      <= 1'b0;
      fb_addr_r    <= '0;
      fb_data_r    <= 1'b0;
      last_r       <= 1'b0;
      fill_done_r  <= 1'b0;
      oe_r         <= 1'b0;
      dout_r       <= 8'h00;
    end else begin
      ctr_r        <= ctr_nxt;
      fill_val_r   <= fill_val_nxt;
      pend_valid_r <= pend_valid_nxt;
      pend_addr_r  <= pend_addr_nxt;
      pend_data_r  <= pend_data_nxt;
      overflow_r   <= overflow_nxt;
      fb_we_r      <= fb_we_nxt;
      fb_addr_r    <= fb_addr_nxt;
      fb_data_r    <= fb_data_nxt;
      last_r       <= last_nxt;
      fill_done_r  <= last_r;
      oe_r         <= rd_status_s;
      dout_r       <= dout_nxt;
    end
  end

  assign bus.FB_WE          = fb_we_r;
  assign bus.FB_ADDR        = fb_addr_r;
  assign bus.FB_DATA        = fb_data_r;
  assign bus.CONFIG_COLOURS = {bg_r, fg_r};
  assign bus.FILL_DONE      = fill_done_r;
  assign bus.BUS_DATA_OE    = oe_r;
  assign bus.BUS_DATA_OUT   = dout_r;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_frame_buffer_ctrl
// Self-checking bench for frame_buffer_ctrl. Expected port A writes are pushed
// to a scoreboard queue as stimulus is driven; a negedge monitor pops and
// compares every FB_WE cycle and checks FILL_DONE follows the last fill write.
// ----------------------------------------------------------------------------
module tb_frame_buffer_ctrl;

  localparam logic [7:0] BASE = 8'hB0;

  logic CLK;
  logic RESET;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_q[$];
  bit   sb_en = 1'b0;
  logic prev_last = 1'b0;

  frame_buffer_ctrl_if #(.ADDR_WIDTH(15)) bus_if ();

  frame_buffer_ctrl #(
    .BASE_ADDR(8'hB0),
    .ADDR_WIDTH(15),
    .DEFAULT_COLOURS(16'h00FF)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scoreboard monitor: every port A write must match the next expected one
  always @(negedge CLK) begin
    if (!RESET) begin
      checks++;
      if (bus_if.FILL_DONE !== prev_last) begin
        errors++;
        $display("FAIL fill_done_timing: got %b expected %b", bus_if.FILL_DONE, prev_last);
      end
      if (sb_en && bus_if.FB_WE === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL fb_write_unexpected: got addr=%h data=%b, expected no write",
                   bus_if.FB_ADDR, bus_if.FB_DATA);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if ({bus_if.FB_ADDR, bus_if.FB_DATA} !== e) begin
            errors++;
            $display("FAIL fb_write: got addr=%h data=%b, expected addr=%h data=%b",
                     bus_if.FB_ADDR, bus_if.FB_DATA, e[15:1], e[0]);
          end
        end
      end
    end
    prev_last = (bus_if.FB_WE === 1'b1) && (bus_if.FB_ADDR === 15'h7FFF);
  end

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    bus_if.BUS_ADDR    = a;
    bus_if.BUS_DATA_IN = d;
    bus_if.BUS_WE      = 1'b1;
  endtask

  task automatic bus_read(input logic [7:0] a);
    @(negedge CLK);
    bus_if.BUS_ADDR    = a;
    bus_if.BUS_DATA_IN = 8'h00;
    bus_if.BUS_WE      = 1'b0;
  endtask

  task automatic bus_idle();
    @(negedge CLK);
    bus_if.BUS_ADDR    = 8'h00;
    bus_if.BUS_DATA_IN = 8'h00;
    bus_if.BUS_WE      = 1'b0;
  endtask

  task automatic status_read(output logic [7:0] d, output logic oe);
    bus_read(BASE + 8'd5);
    bus_idle();
    d  = bus_if.BUS_DATA_OUT;
    oe = bus_if.BUS_DATA_OE;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bus_if.FB_WE !== 1'b0 || bus_if.FB_ADDR !== 15'h0000 || bus_if.FB_DATA !== 1'b0 ||
        bus_if.CONFIG_COLOURS !== 16'h00FF || bus_if.BUS_DATA_OE !== 1'b0 ||
        bus_if.BUS_DATA_OUT !== 8'h00 || bus_if.FILL_DONE !== 1'b0) begin
      errors++;
      $display("FAIL %s: got we=%b addr=%h data=%b col=%h oe=%b dout=%h done=%b, expected 0 0000 0 00ff 0 00 0",
               tag, bus_if.FB_WE, bus_if.FB_ADDR, bus_if.FB_DATA, bus_if.CONFIG_COLOURS,
               bus_if.BUS_DATA_OE, bus_if.BUS_DATA_OUT, bus_if.FILL_DONE);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic oe;
    RESET = 1'b1;
    bus_if.BUS_ADDR = 8'h00; bus_if.BUS_DATA_IN = 8'h00; bus_if.BUS_WE = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_outputs("reset_initial");
    RESET = 1'b0;
    // Start an aborted fill with non-default colours, then reset mid-cycle
    bus_write(BASE + 8'd3, 8'h55);
    bus_write(BASE + 8'd5, 8'h03);
    bus_idle();
    repeat (10) @(negedge CLK);
    checks++;
    if (bus_if.FB_WE !== 1'b1 || bus_if.CONFIG_COLOURS !== 16'h0055) begin
      errors++;
      $display("FAIL reset_prefill: got we=%b col=%h, expected 1 0055", bus_if.FB_WE, bus_if.CONFIG_COLOURS);
    end
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1 check_reset_outputs("reset_midcycle");
    @(negedge CLK);
    RESET = 1'b0;
    exp_q.delete();
    sb_en = 1'b1;
    status_read(d, oe);
    checks++;
    if (oe !== 1'b1 || d !== 8'h00) begin
      errors++;
      $display("FAIL reset_status: got oe=%b data=%h, expected 1 00", oe, d);
    end
  endtask

  task automatic test_pixel();
    bus_write(BASE + 8'd0, 8'h10);
    bus_write(BASE + 8'd1, 8'h85);        // bit7 of Y must be ignored
    exp_q.push_back({15'h0510, 1'b1});
    bus_write(BASE + 8'd2, 8'h01);
    bus_idle();
    checks++;
    if (bus_if.FB_WE !== 1'b1 || bus_if.FB_ADDR !== 15'h0510 || bus_if.FB_DATA !== 1'b1) begin
      errors++;
      $display("FAIL pixel_latency: got we=%b addr=%h data=%b, expected 1 0510 1",
               bus_if.FB_WE, bus_if.FB_ADDR, bus_if.FB_DATA);
    end
    bus_idle();
    checks++;
    if (bus_if.FB_WE !== 1'b0) begin
      errors++;
      $display("FAIL pixel_single_cycle: got we=%b expected 0", bus_if.FB_WE);
    end
    // Accesses that must never write port A
    bus_write(BASE + 8'd6, 8'h01);
    bus_write(BASE - 8'd1, 8'h01);
    bus_read(BASE + 8'd2);
    bus_write(BASE + 8'd3, 8'h00);
    bus_idle();
    bus_idle();
    checks++;
    if (bus_if.FB_WE !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL pixel_nonpixel_access: got we=%b pending_exp=%0d, expected 0 0", bus_if.FB_WE, exp_q.size());
    end
  endtask

  task automatic test_colours();
    bus_write(BASE + 8'd3, 8'hE0);
    bus_idle();
    checks++;
    if (bus_if.CONFIG_COLOURS !== 16'h00E0) begin
      errors++;
      $display("FAIL colours_fg: got %h expected 00e0", bus_if.CONFIG_COLOURS);
    end
    bus_write(BASE + 8'd4, 8'h1C);
    bus_idle();
    checks++;
    if (bus_if.CONFIG_COLOURS !== 16'h1CE0) begin
      errors++;
      $display("FAIL colours_bg: got %h expected 1ce0", bus_if.CONFIG_COLOURS);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic oe;
    bus_write(BASE + 8'd1, 8'h7F);
    bus_write(BASE + 8'd0, 8'h20);
    exp_q.push_back({15'h7F20, 1'b1});
    exp_q.push_back({15'h7F20, 1'b0});
    bus_write(BASE + 8'd2, 8'h01);
    bus_write(BASE + 8'd2, 8'h00);
    bus_idle();
    bus_idle();
    status_read(d, oe);
    checks++;
    if (exp_q.size() != 0 || d !== 8'h00 || oe !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back: got left=%0d status=%h oe=%b, expected 0 00 1", exp_q.size(), d, oe);
    end
  endtask

  task automatic test_fill();
    int we_cnt = 0;
    bit seen_end = 1'b0;
    logic [7:0] d;
    logic oe;
    for (int i = 0; i < 32768; i++) exp_q.push_back({15'(i), 1'b1});
    bus_write(BASE + 8'd5, 8'h03);
    bus_idle();
    for (int cyc = 0; cyc < 40000; cyc++) begin
      @(negedge CLK);
      if (cyc == 50) begin
        // Start with a different fill value while busy: must be ignored
        bus_if.BUS_ADDR = BASE + 8'd5; bus_if.BUS_DATA_IN = 8'h01; bus_if.BUS_WE = 1'b1;
      end else if (cyc == 51) begin
        bus_if.BUS_ADDR = 8'h00; bus_if.BUS_DATA_IN = 8'h00; bus_if.BUS_WE = 1'b0;
      end else if (cyc == 100) begin
        bus_if.BUS_ADDR = BASE + 8'd5;
      end else if (cyc == 101) begin
        checks++;
        if (bus_if.BUS_DATA_OE !== 1'b1 || bus_if.BUS_DATA_OUT !== 8'h01) begin
          errors++;
          $display("FAIL fill_busy_status: got oe=%b data=%h, expected 1 01",
                   bus_if.BUS_DATA_OE, bus_if.BUS_DATA_OUT);
        end
        bus_if.BUS_ADDR = 8'h00;
      end else begin
        bus_if.BUS_WE = 1'b0;
      end
      if (bus_if.FB_WE === 1'b1) begin
        we_cnt++;
      end else if (we_cnt > 0) begin
        seen_end = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen_end || we_cnt != 32768) begin
      errors++;
      $display("FAIL fill_consecutive: got finished=%0d count=%0d, expected 1 32768", seen_end, we_cnt);
    end
    checks++;
    if (bus_if.FILL_DONE !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL fill_done: got done=%b left=%0d, expected 1 0", bus_if.FILL_DONE, exp_q.size());
    end
    bus_idle();
    checks++;
    if (bus_if.FILL_DONE !== 1'b0) begin
      errors++;
      $display("FAIL fill_done_pulse: got %b expected 0", bus_if.FILL_DONE);
    end
    status_read(d, oe);
    checks++;
    if (d !== 8'h00 || oe !== 1'b1) begin
      errors++;
      $display("FAIL fill_idle_status: got data=%h oe=%b, expected 00 1", d, oe);
    end
    exp_q.delete();
  endtask

  task automatic test_arbitration();
    logic [7:0] d;
    logic oe;
    bit done_seen = 1'b0;
    bus_write(BASE + 8'd0, 8'h02);
    bus_write(BASE + 8'd1, 8'h00);
    bus_idle();
    // Fill value 1; pixel at ctr 99->100 yields, ctr holds 100; pixel A at
    // 150 yields, ctr holds 151, and the back-to-back pixel B is dropped.
    for (int i = 0; i < 100; i++) exp_q.push_back({15'(i), 1'b1});
    exp_q.push_back({15'h0002, 1'b0});
    for (int i = 100; i < 151; i++) exp_q.push_back({15'(i), 1'b1});
    exp_q.push_back({15'h0307, 1'b0});
    for (int i = 151; i < 32768; i++) exp_q.push_back({15'(i), 1'b1});
    bus_write(BASE + 8'd5, 8'h03);        // sampled at edge S
    bus_idle();
    repeat (98) @(negedge CLK);
    bus_write(BASE + 8'd2, 8'h00);        // sampled at edge S+100
    bus_idle();
    repeat (48) @(negedge CLK);
    bus_write(BASE + 8'd0, 8'h07);        // S+150
    bus_write(BASE + 8'd1, 8'h03);        // S+151
    bus_write(BASE + 8'd2, 8'h00);        // S+152 pixel A
    bus_write(BASE + 8'd2, 8'h01);        // S+153 pixel B, dropped
    status_read(d, oe);
    checks++;
    if (d !== 8'h03 || oe !== 1'b1) begin
      errors++;
      $display("FAIL overflow_status_set: got data=%h oe=%b, expected 03 1", d, oe);
    end
    status_read(d, oe);
    checks++;
    if (d !== 8'h01 || oe !== 1'b1) begin
      errors++;
      $display("FAIL overflow_status_cleared: got data=%h oe=%b, expected 01 1", d, oe);
    end
    for (int cyc = 0; cyc < 40000; cyc++) begin
      @(negedge CLK);
      if (bus_if.FILL_DONE === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!done_seen || exp_q.size() != 0) begin
      errors++;
      $display("FAIL arbitration_complete: got done=%0d left=%0d, expected 1 0", done_seen, exp_q.size());
    end
    status_read(d, oe);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL arbitration_final_status: got %h expected 00", d);
    end
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_colours();
    test_back_to_back();
    test_fill();
    test_arbitration();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
